// File: rtl/osr_pull_ctrl_pkg.sv
// Shared OSR/ISR shift-count types and threshold decode.
// The ISR autopush controller is expected to reuse thresh_decode.
package osr_pull_ctrl_pkg;

  typedef logic [5:0] osr_cnt_t;

  localparam osr_cnt_t OSR_EMPTY_CNT = 6'd32;

  // A threshold field of 0 means a full 32-bit word.
  function automatic osr_cnt_t thresh_decode(input logic [4:0] thresh);
    return (thresh == 5'd0) ? OSR_EMPTY_CNT : {1'b0, thresh};
  endfunction

endpackage

// File: rtl/osr_pull_ctrl.sv
// OSR fill/empty accounting and TX FIFO read arbitration for PULL, MOV->OSR,
// OUT and autopull. Every control output is combinational from the inputs and r_osr_count.
module osr_pull_ctrl
  import osr_pull_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sm_en,
  input  logic              exec_out,
  input  logic [CNT_W-1:0]  out_count,
  input  logic              exec_pull,
  input  logic              pull_block,
  input  logic              pull_ifempty,
  input  logic              exec_mov_osr,
  input  logic [DATA_W-1:0] mov_data,
  input  logic [DATA_W-1:0] x_data,
  input  logic              autopull_en,
  input  logic [4:0]        pull_thresh,
  input  logic              txf_empty,
  input  logic [DATA_W-1:0] txf_rdata,
  output logic              txf_rd_en,
  output logic              osr_load,
  output logic [DATA_W-1:0] osr_data_in,
  output logic              osr_shift_en,
  output logic [CNT_W-1:0]  osr_shift_count,
  output logic              stall,
  output logic [CNT_W-1:0]  osr_count
);

  osr_cnt_t   r_osr_count;
  osr_cnt_t   w_next_count;
  logic       w_full_used;
  logic [6:0] w_sum;

  assign w_full_used = (r_osr_count >= thresh_decode(pull_thresh));
  assign w_sum       = {1'b0, r_osr_count} + {1'b0, out_count};
  assign osr_count   = r_osr_count;

  // FIFO handshake: txf_empty low means txf_rdata is valid; raising txf_rd_en
  // consumes that word in this cycle and is only ever done while txf_empty is low.
  always_comb begin
    txf_rd_en       = 1'b0;
    osr_load        = 1'b0;
    osr_data_in     = '0;
    osr_shift_en    = 1'b0;
    osr_shift_count = '0;
    stall           = 1'b0;
    w_next_count    = r_osr_count;
    if (!rst && sm_en) begin
      if (exec_mov_osr) begin
        osr_load     = 1'b1;
        osr_data_in  = mov_data;
        w_next_count = '0;
      end else if (exec_pull) begin
        if (pull_ifempty && !w_full_used) begin
          w_next_count = r_osr_count;
        end else if (!txf_empty) begin
          txf_rd_en    = 1'b1;
          osr_load     = 1'b1;
          osr_data_in  = txf_rdata;
          w_next_count = '0;
        end else if (pull_block) begin
          stall = 1'b1;
        end else begin
          osr_load     = 1'b1;
          osr_data_in  = x_data;
          w_next_count = '0;
        end
      end else if (exec_out) begin
        // An exhausted OSR refills first; OUT re-executes on the fresh word.
        if (autopull_en && w_full_used) begin
          stall = 1'b1;
          if (!txf_empty) begin
            txf_rd_en    = 1'b1;
            osr_load     = 1'b1;
            osr_data_in  = txf_rdata;
            w_next_count = '0;
          end
        end else begin
          osr_shift_en    = 1'b1;
          osr_shift_count = out_count;
          w_next_count    = (w_sum > 7'd32) ? OSR_EMPTY_CNT : w_sum[5:0];
        end
      end else if (autopull_en && w_full_used && !txf_empty) begin
        txf_rd_en    = 1'b1;
        osr_load     = 1'b1;
        osr_data_in  = txf_rdata;
        w_next_count = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_osr_count <= OSR_EMPTY_CNT;
    end else begin
      r_osr_count <= w_next_count;
    end
  end

endmodule

// File: tb/tb_osr_pull_ctrl.sv
// Directed bench for osr_pull_ctrl: a word-level OSR model checked every cycle
// plus literal expectations taken from hand-worked scenarios.
module tb_osr_pull_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sm_en = 1'b1;
  logic        exec_out = 1'b0;
  logic [5:0]  out_count = 6'd1;
  logic        exec_pull = 1'b0;
  logic        pull_block = 1'b0;
  logic        pull_ifempty = 1'b0;
  logic        exec_mov_osr = 1'b0;
  logic [31:0] mov_data = '0;
  logic [31:0] x_data = '0;
  logic        autopull_en = 1'b0;
  logic [4:0]  pull_thresh = 5'd0;
  logic        txf_empty = 1'b1;
  logic [31:0] txf_rdata = '0;
  logic        txf_rd_en;
  logic        osr_load;
  logic [31:0] osr_data_in;
  logic        osr_shift_en;
  logic [5:0]  osr_shift_count;
  logic        stall;
  logic [5:0]  osr_count;

  int n_checks = 0;
  int n_fail   = 0;

  osr_pull_ctrl dut (
    .clk(clk), .rst(rst), .sm_en(sm_en), .exec_out(exec_out), .out_count(out_count),
    .exec_pull(exec_pull), .pull_block(pull_block), .pull_ifempty(pull_ifempty),
    .exec_mov_osr(exec_mov_osr), .mov_data(mov_data), .x_data(x_data),
    .autopull_en(autopull_en), .pull_thresh(pull_thresh), .txf_empty(txf_empty),
    .txf_rdata(txf_rdata), .txf_rd_en(txf_rd_en), .osr_load(osr_load),
    .osr_data_in(osr_data_in), .osr_shift_en(osr_shift_en),
    .osr_shift_count(osr_shift_count), .stall(stall), .osr_count(osr_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: bits already consumed from the OSR word (32 = nothing left).
  int m_used = 32;
  int m_used_next = 32;

  typedef struct {
    bit          pop;
    bit          load;
    logic [31:0] word;
    bit          shift;
    int          shift_n;
    bit          stall;
    int          used_after;
  } exp_t;

  function automatic exp_t predict(input int used);
    exp_t e;
    int   thr;
    bit   exhausted;
    e = '{0, 0, 32'h0, 0, 0, 0, used};
    thr = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    exhausted = (used >= thr);
    if (rst || !sm_en) return e;
    if (exec_mov_osr) begin
      e.load = 1; e.word = mov_data; e.used_after = 0;
    end else if (exec_pull) begin
      if (pull_ifempty && !exhausted) begin
        // nothing happens
      end else if (!txf_empty) begin
        e.pop = 1; e.load = 1; e.word = txf_rdata; e.used_after = 0;
      end else if (pull_block) begin
        e.stall = 1;
      end else begin
        e.load = 1; e.word = x_data; e.used_after = 0;
      end
    end else if (exec_out) begin
      if (autopull_en && exhausted) begin
        e.stall = 1;
        if (!txf_empty) begin
          e.pop = 1; e.load = 1; e.word = txf_rdata; e.used_after = 0;
        end
      end else begin
        e.shift = 1; e.shift_n = int'(out_count);
        e.used_after = (used + int'(out_count) > 32) ? 32 : used + int'(out_count);
      end
    end else if (autopull_en && exhausted && !txf_empty) begin
      e.pop = 1; e.load = 1; e.word = txf_rdata; e.used_after = 0;
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_used <= 32;
    else     m_used <= m_used_next;
  end

  // Compare process: inputs change just after posedge, so negedge sees them settled.
  always @(negedge clk) begin
    exp_t e;
    e = predict(m_used);
    chk("m_txf_rd_en",   32'(txf_rd_en),       32'(e.pop));
    chk("m_osr_load",    32'(osr_load),        32'(e.load));
    chk("m_osr_data_in", osr_data_in,          e.word);
    chk("m_shift_en",    32'(osr_shift_en),    32'(e.shift));
    chk("m_shift_count", 32'(osr_shift_count), 32'(e.shift_n));
    chk("m_stall",       32'(stall),           32'(e.stall));
    chk("m_osr_count",   32'(osr_count),       32'(m_used));
    m_used_next = e.used_after;
  end

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic no_exec();
    exec_out = 0; exec_pull = 0; exec_mov_osr = 0;
    pull_block = 0; pull_ifempty = 0;
  endtask

  task automatic do_out(input logic [5:0] n);
    no_exec(); exec_out = 1; out_count = n;
    adv();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with refill pending: outputs must stay quiet while rst is high.
    autopull_en = 1; pull_thresh = 5'd0;
    txf_empty = 0; txf_rdata = 32'hDEADBEEF;
    settle();
    chk("rst_rd_en", 32'(txf_rd_en), 32'd0);
    chk("rst_count", 32'(osr_count), 32'd32);
    adv();
    rst = 0;
    settle();
    chk("ap_rd_en", 32'(txf_rd_en), 32'd1);
    chk("ap_load",  32'(osr_load),  32'd1);
    chk("ap_data",  osr_data_in,    32'hDEADBEEF);
    adv();
    chk("ap_count", 32'(osr_count), 32'd0);
    txf_empty = 1;

    // OUT 8 with thr=8, then background refill.
    pull_thresh = 5'd8;
    no_exec(); exec_out = 1; out_count = 6'd8;
    settle();
    chk("out8_shift", 32'(osr_shift_en),    32'd1);
    chk("out8_n",     32'(osr_shift_count), 32'd8);
    adv();
    chk("out8_count", 32'(osr_count), 32'd8);
    no_exec(); txf_empty = 0; txf_rdata = 32'h11111111;
    settle();
    chk("bg_rd_en", 32'(txf_rd_en), 32'd1);
    adv();
    chk("bg_count", 32'(osr_count), 32'd0);
    txf_empty = 1;

    // Refill-on-OUT stall with empty FIFO, then the word arrives.
    do_out(6'd8);
    chk("pre_stall_count", 32'(osr_count), 32'd8);
    exec_out = 1; out_count = 6'd4;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("out_stall", 32'(stall), 32'd1);
      chk("out_noshift", 32'(osr_shift_en), 32'd0);
      adv();
    end
    txf_empty = 0; txf_rdata = 32'h00001234;
    settle();
    chk("refill_stall", 32'(stall), 32'd1);
    chk("refill_data", osr_data_in, 32'h00001234);
    adv();
    chk("refill_count", 32'(osr_count), 32'd0);
    txf_empty = 1;
    settle();
    chk("reexec_stall", 32'(stall), 32'd0);
    chk("reexec_shift", 32'(osr_shift_en), 32'd1);
    adv();
    chk("reexec_count", 32'(osr_count), 32'd4);

    // Blocking PULL on empty FIFO, then data; non-blocking PULL loads X.
    no_exec(); exec_pull = 1; pull_block = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("pull_stall", 32'(stall), 32'd1);
      adv();
    end
    txf_empty = 0; txf_rdata = 32'hA5A5A5A5;
    settle();
    chk("pull_data", osr_data_in, 32'hA5A5A5A5);
    chk("pull_pop",  32'(txf_rd_en), 32'd1);
    adv();
    chk("pull_count", 32'(osr_count), 32'd0);
    txf_empty = 1; pull_block = 0; x_data = 32'h77;
    settle();
    chk("pullx_data", osr_data_in, 32'h77);
    chk("pullx_nopop", 32'(txf_rd_en), 32'd0);
    adv();

    // Saturation, PULL ifempty no-op, MOV to OSR.
    autopull_en = 0; pull_thresh = 5'd0;
    do_out(6'd30);
    chk("sat_pre", 32'(osr_count), 32'd30);
    do_out(6'd5);
    chk("sat_count", 32'(osr_count), 32'd32);
    no_exec(); exec_mov_osr = 1; mov_data = 32'h0; adv();
    do_out(6'd16);
    no_exec(); exec_pull = 1; pull_ifempty = 1; pull_block = 1; txf_empty = 0;
    settle();
    chk("ifempty_load", 32'(osr_load), 32'd0);
    chk("ifempty_pop",  32'(txf_rd_en), 32'd0);
    adv();
    chk("ifempty_count", 32'(osr_count), 32'd16);
    do_out(6'd16);
    no_exec(); exec_mov_osr = 1; mov_data = 32'hCAFE;
    settle();
    chk("mov_data", osr_data_in, 32'hCAFE);
    chk("mov_nopop", 32'(txf_rd_en), 32'd0);
    adv();
    chk("mov_count", 32'(osr_count), 32'd0);

    // Disabled state machine freezes everything.
    sm_en = 0; no_exec(); exec_out = 1; out_count = 6'd3;
    settle();
    chk("dis_shift", 32'(osr_shift_en), 32'd0);
    adv();
    chk("dis_count", 32'(osr_count), 32'd0);
    sm_en = 1; txf_empty = 1;

    // Reset during a blocked PULL stall.
    autopull_en = 1; no_exec(); exec_pull = 1; pull_block = 1;
    settle();
    chk("pre_rst_stall", 32'(stall), 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_async_count", 32'(osr_count), 32'd32);
    no_exec(); txf_empty = 0; txf_rdata = 32'hBEEF0001;
    adv();
    rst = 0;
    settle();
    chk("post_rst_pop", 32'(txf_rd_en), 32'd1);
    chk("post_rst_data", osr_data_in, 32'hBEEF0001);
    adv();
    chk("post_rst_count", 32'(osr_count), 32'd0);
    txf_empty = 1;
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
